// File: rtl/mips_dump_pkg.sv
// Shared types and default sizes for the memory dump reader.
// Holds the FSM state enum and the default widths/depth.
package mips_dump_pkg;

  localparam int DUMP_ADDR_W = 32;
  localparam int DUMP_DATA_W = 32;
  localparam int DUMP_CNT_W  = 16;
  localparam int DUMP_FIFO_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } dump_state_t;

endpackage

// File: rtl/dump_fifo.sv
// Synchronous FIFO of {adr, data} entries for the dump reader.
// Ports: push/push_adr/push_data in, pop in, head_adr/head_data, full, empty, count out.
module dump_fifo #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     push,
  input  logic [AW-1:0]            push_adr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_adr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

  assign do_pop  = pop && !empty;
  // a push into a full FIFO is only legal when the head leaves the same cycle
  assign do_push = push && (!full || do_pop);

  assign head_adr  = mem[rptr][AW+DW-1:DW];
  assign head_data = mem[rptr][DW-1:0];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= {push_adr, push_data};
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a word-addressed memory region out through a valid/ready port.
// Ports: start/base_adr/word_cnt request, mem_rd_* read port, dump_* stream,
// busy/done status; dump_sum only when DUMP_CHECKSUM_EN is defined.
module mem_dump_reader
  import mips_dump_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W,
  parameter int CNT_W  = DUMP_CNT_W,
  parameter int FIFO_D = DUMP_FIFO_D
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_adr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_adr,
  output logic              busy,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] dump_sum
`endif
);

  localparam int CW = $clog2(FIFO_D) + 1;

  dump_state_t       state;
  dump_state_t       nxt;
  logic [ADDR_W-1:0] adr;
  logic [ADDR_W-1:0] fl_adr;
  logic [CNT_W-1:0]  rd_left;
  logic [CNT_W-1:0]  hs_left;
  logic              inflight;
  logic              accept;
  logic              rd_en;
  logic              pop;
  logic              room;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] head_adr;
  logic [DATA_W-1:0] head_data;
  logic              full;
  logic              empty;
  logic [CW-1:0]     fcount;

  assign accept = (state == IDLE) && start;
  assign pop    = !empty && dump_ready;

  // entries that will be held after this edge if nothing new is issued
  assign occ  = {1'b0, fcount}
              + {{CW{1'b0}}, inflight}
              - {{CW{1'b0}}, pop};
  assign room = (occ < (CW+1)'(FIFO_D)) && !(full && !pop);

  always_comb begin
    nxt   = state;
    rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nxt = (word_cnt == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_en = room;
        if (room && rd_left == CNT_W'(1)) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        // the last handshake empties the pipe: nothing left in flight
        if (pop && hs_left == CNT_W'(1)) begin
          nxt = DONE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      adr      <= '0;
      fl_adr   <= '0;
      rd_left  <= '0;
      hs_left  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= nxt;
      inflight <= rd_en;
      if (accept) begin
        adr     <= base_adr;
        rd_left <= word_cnt;
        hs_left <= word_cnt;
      end
      if (rd_en) begin
        adr     <= adr + ADDR_W'(1);
        rd_left <= rd_left - CNT_W'(1);
        fl_adr  <= adr;
      end
      if (pop) begin
        hs_left <= hs_left - CNT_W'(1);
      end
    end
  end

  dump_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .push      (inflight),
    .push_adr  (fl_adr),
    .push_data (mem_rd_data),
    .pop       (pop),
    .head_adr  (head_adr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (fcount)
  );

  assign mem_rd_en  = rd_en;
  assign mem_rd_adr = adr;
  assign dump_valid = !empty;
  // storage is not reset, so the head is masked while empty
  assign dump_data  = empty ? '0 : head_data;
  assign dump_adr   = empty ? '0 : head_adr;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      dump_sum <= '0;
    end else if (accept) begin
      dump_sum <= '0;
    end else if (pop) begin
      dump_sum <= dump_sum + head_data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader.
// Drives at posedge+1, samples at negedge.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        res;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_cnt;
  logic        mem_rd_en;
  logic [31:0] mem_rd_adr;
  logic [31:0] mem_rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [31:0] dump_adr;
  logic        busy;
  logic        done;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] dump_sum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [64];
  int          cyc = 0;
  int          rd_cnt;
  int          done_cnt;
  int          done_cyc;
  int          hs_first;
  int          hs_last;
  int          stab_err;
  int          max_out;
  logic [31:0] hs_a[$];
  logic [31:0] hs_d[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [31:0] prev_a;

  mem_dump_reader dut (
    .clk         (clk),
    .res         (res),
    .start       (start),
    .base_adr    (base_adr),
    .word_cnt    (word_cnt),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_adr  (mem_rd_adr),
    .mem_rd_data (mem_rd_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_adr    (dump_adr),
    .busy        (busy),
    .done        (done)
`ifdef DUMP_CHECKSUM_EN
    ,
    .dump_sum    (dump_sum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_adr[5:0]];
  end

  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_stall) begin
      if (dump_data !== prev_d || dump_adr !== prev_a) stab_err++;
    end
    if (dump_valid && dump_ready) begin
      if (hs_a.size() == 0) hs_first = cyc;
      hs_last = cyc;
      hs_a.push_back(dump_adr);
      hs_d.push_back(dump_data);
    end
    prev_stall = dump_valid && !dump_ready;
    prev_d = dump_data;
    prev_a = dump_adr;
    if (rd_cnt - hs_a.size() > max_out) max_out = rd_cnt - hs_a.size();
  end

  task automatic clr();
    hs_a.delete();
    hs_d.delete();
    rd_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    stab_err = 0;
    max_out = 0;
  endtask

  task automatic kick(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1;
    base_adr = b;
    word_cnt = n;
    @(posedge clk); #1;
    start = 1'b0;
    base_adr = 32'h1234_5678;
    word_cnt = 16'd9;
  endtask

  task automatic wait_done(input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (toggle) dump_ready = ~dump_ready;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    res = 1'b0;
    start = 1'b0;
    base_adr = '0;
    word_cnt = '0;
    dump_ready = 1'b1;
    mem_rd_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, dump_valid, mem_rd_en} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, dump_valid, mem_rd_en});
    end
    n_cmp++;
    if (mem_rd_adr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_rd_adr: got %h want 0", mem_rd_adr);
    end
    n_cmp++;
    if (dump_data !== 32'd0 || dump_adr !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_dump: got %h/%h want 0/0", dump_data, dump_adr);
    end
`ifdef DUMP_CHECKSUM_EN
    n_cmp++;
    if (dump_sum !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_sum: got %h want 0", dump_sum);
    end
`endif
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    clr();
    dump_ready = 1'b1;
    kick(32'd11, 16'd1);
    @(negedge clk);
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_rd_adr !== 32'd11) begin
      n_bad++;
      $display("FAIL single_issue: got en=%b adr=%h want en=1 adr=b",
               mem_rd_en, mem_rd_adr);
    end
    @(negedge clk);
    n_cmp++;
    if (dump_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early_valid: got %b want 0", dump_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (dump_valid !== 1'b1 || dump_data !== 32'd27 ||
        dump_adr !== 32'd11) begin
      n_bad++;
      $display("FAIL single_word: got v=%b d=%0d a=%0d want v=1 d=27 a=11",
               dump_valid, dump_data, dump_adr);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL single_done: got %b want 1", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after: got done=%b busy=%b want 0 0", done, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rd_cnt !== 1 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL single_counts: got rd=%0d done=%0d want 1 1",
               rd_cnt, done_cnt);
    end
  endtask

  task automatic test_stream();
    bit ok;
    logic [31:0] ed [6] = '{32'd11, 32'd12, 32'd15, 32'd27, 32'd0, 32'd5};
    clr();
    dump_ready = 1'b1;
    kick(32'd0, 16'd6);
    wait_done(1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL stream_timeout: got %b want 1", ok);
    end
    n_cmp++;
    if (hs_a.size() !== 6) begin
      n_bad++;
      $display("FAIL stream_count: got %0d want 6", hs_a.size());
    end
    for (int i = 0; i < 6 && i < hs_a.size(); i++) begin
      n_cmp++;
      if (hs_a[i] !== i || hs_d[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL stream_word%0d: got a=%0d d=%0d want a=%0d d=%0d",
                 i, hs_a[i], hs_d[i], i, ed[i]);
      end
    end
    n_cmp++;
    if (hs_last - hs_first !== 5) begin
      n_bad++;
      $display("FAIL stream_rate: got span %0d want 5", hs_last - hs_first);
    end
    n_cmp++;
    if (done_cyc - hs_last !== 1 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL stream_done: got gap=%0d n=%0d want 1 1",
               done_cyc - hs_last, done_cnt);
    end
`ifdef DUMP_CHECKSUM_EN
    n_cmp++;
    if (dump_sum !== 32'd70) begin
      n_bad++;
      $display("FAIL stream_sum: got %0d want 70", dump_sum);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] ed [6] = '{32'd11, 32'd12, 32'd15, 32'd27, 32'd0, 32'd5};
    clr();
    dump_ready = 1'b1;
    kick(32'd0, 16'd6);
    start = 1'b1;
    base_adr = 32'd40;
    word_cnt = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, ok);
    dump_ready = 1'b1;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_timeout: got %b want 1", ok);
    end
    n_cmp++;
    if (hs_a.size() !== 6 || rd_cnt !== 6 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL bp_counts: got hs=%0d rd=%0d done=%0d want 6 6 1",
               hs_a.size(), rd_cnt, done_cnt);
    end
    for (int i = 0; i < 6 && i < hs_a.size(); i++) begin
      n_cmp++;
      if (hs_a[i] !== i || hs_d[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL bp_word%0d: got a=%0d d=%0d want a=%0d d=%0d",
                 i, hs_a[i], hs_d[i], i, ed[i]);
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin
      n_bad++;
      $display("FAIL bp_stable: got %0d changes want 0", stab_err);
    end
    n_cmp++;
    if (max_out > 4) begin
      n_bad++;
      $display("FAIL bp_overflow: got %0d outstanding want <=4", max_out);
    end
  endtask

  task automatic test_zero_wrap();
    bit ok;
    logic [31:0] ea [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] ed [4] = '{32'hDEAD_0062, 32'hDEAD_0063, 32'd11, 32'd12};
    clr();
    kick(32'd5, 16'd0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_done: got %b want 1", done);
    end
`ifdef DUMP_CHECKSUM_EN
    n_cmp++;
    if (dump_sum !== 32'd0) begin
      n_bad++;
      $display("FAIL sum_clear: got %0d want 0", dump_sum);
    end
`endif
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_cnt !== 0) begin
      n_bad++;
      $display("FAIL zero_after: got done=%b busy=%b rd=%0d want 0 0 0",
               done, busy, rd_cnt);
    end
    @(posedge clk); #1;
    clr();
    kick(32'hFFFF_FFFE, 16'd4);
    wait_done(1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1 || hs_a.size() !== 4) begin
      n_bad++;
      $display("FAIL wrap_count: got ok=%b n=%0d want 1 4", ok, hs_a.size());
    end
    for (int i = 0; i < 4 && i < hs_a.size(); i++) begin
      n_cmp++;
      if (hs_a[i] !== ea[i] || hs_d[i] !== ed[i]) begin
        n_bad++;
        $display("FAIL wrap_word%0d: got a=%h d=%h want a=%h d=%h",
                 i, hs_a[i], hs_d[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr();
    dump_ready = 1'b1;
    kick(32'd0, 16'd6);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (hs_a.size() >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_timeout: got %b want 1", ok);
    end
    #2 res = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, dump_valid, mem_rd_en} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_flags: got %b want 0000",
               {busy, done, dump_valid, mem_rd_en});
    end
    n_cmp++;
    if (dump_data !== 32'd0 || dump_adr !== 32'd0 ||
        mem_rd_adr !== 32'd0) begin
      n_bad++;
      $display("FAIL mid_buses: got %h/%h/%h want 0/0/0",
               dump_data, dump_adr, mem_rd_adr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    clr();
    kick(32'd0, 16'd2);
    wait_done(1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1 || hs_a.size() !== 2) begin
      n_bad++;
      $display("FAIL post_count: got ok=%b n=%0d want 1 2", ok, hs_a.size());
    end
    if (hs_a.size() == 2) begin
      n_cmp++;
      if (hs_a[0] !== 32'd0 || hs_d[0] !== 32'd11 ||
          hs_a[1] !== 32'd1 || hs_d[1] !== 32'd12) begin
        n_bad++;
        $display("FAIL post_words: got %0d:%0d %0d:%0d want 0:11 1:12",
                 hs_a[0], hs_d[0], hs_a[1], hs_d[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hBAD0_0000 | i;
    mem[0]  = 32'd11;
    mem[1]  = 32'd12;
    mem[2]  = 32'd15;
    mem[3]  = 32'd27;
    mem[4]  = 32'd0;
    mem[5]  = 32'd5;
    mem[11] = 32'd27;
    mem[62] = 32'hDEAD_0062;
    mem[63] = 32'hDEAD_0063;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_zero_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
